// File: rtl/dma_wr_sched_pkg.sv
// Shared definitions for the write-DMA scheduler: default geometry, FSM encoding and
// round-robin pointer helper.
package dma_wr_sched_pkg;

  localparam int unsigned DefNumReq       = 4;
  localparam int unsigned DefOutBitsTrans = 13;
  localparam int unsigned DefAxiWidthAd   = 32;
  localparam int unsigned DefAxiWidthDa   = 32;
  localparam int unsigned DefTimeout      = 65535;

  // Saturation ceiling of the burst-failure counter
  localparam logic [7:0] FailCntMax = 8'hFF;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArb   = 3'd1,
    StStart = 3'd2,
    StRun   = 3'd3,
    StFin   = 3'd4
  } sched_state_e;

  // Index following idx in a ring of n entries
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dma_wr_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module dma_wr_sched_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               found
);

  logic [IDX_W-1:0] cand;

  // Scan the ring starting at ptr and keep the first hit
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (found) gnt_oh[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/dma_wr_sched.sv
// Round-robin scheduler sharing one AXI write DMA among NUM_REQ output buffers.
// Grants a job, launches the DMA, steers buffer reads/data for the granted requester,
// and reports completion, burst failures and watchdog aborts.
module dma_wr_sched
  import dma_wr_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DefNumReq,
  parameter int unsigned OUT_BITS_TRANS = DefOutBitsTrans,
  parameter int unsigned AXI_WIDTH_AD   = DefAxiWidthAd,
  parameter int unsigned AXI_WIDTH_DA   = DefAxiWidthDa,
  parameter int unsigned TIMEOUT        = DefTimeout
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ*AXI_WIDTH_AD-1:0]    req_addr_i,
  input  logic [NUM_REQ*OUT_BITS_TRANS-1:0]  req_len_i,
  output logic [NUM_REQ-1:0]                 req_ack_o,
  output logic [NUM_REQ-1:0]                 req_done_o,
  output logic [NUM_REQ-1:0]                 buf_rd_o,
  input  logic [NUM_REQ*AXI_WIDTH_DA-1:0]    buf_data_i,
  output logic                               dma_start_o,
  output logic [OUT_BITS_TRANS-1:0]          dma_num_trans_o,
  output logic [AXI_WIDTH_AD-1:0]            dma_addr_o,
  output logic [AXI_WIDTH_DA-1:0]            dma_indata_o,
  input  logic                               dma_req_i,
  input  logic                               dma_done_i,
  input  logic                               dma_fail_i,
  output logic                               busy_o,
  output logic [$clog2(NUM_REQ)-1:0]         grant_o,
  output logic [7:0]                         fail_cnt_o,
  output logic                               err_o,
  input  logic                               err_clr_i
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

  logic [AXI_WIDTH_AD-1:0]   addr_arr [NUM_REQ];
  logic [OUT_BITS_TRANS-1:0] len_arr  [NUM_REQ];
  logic [AXI_WIDTH_DA-1:0]   data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_arr[i] = req_addr_i[i*AXI_WIDTH_AD +: AXI_WIDTH_AD];
    assign len_arr[i]  = req_len_i[i*OUT_BITS_TRANS +: OUT_BITS_TRANS];
    assign data_arr[i] = buf_data_i[i*AXI_WIDTH_DA +: AXI_WIDTH_DA];
  end

  sched_state_e              state_q;
  logic [IdxW-1:0]           grant_q, ptr_q;
  logic [AXI_WIDTH_AD-1:0]   addr_q;
  logic [OUT_BITS_TRANS-1:0] len_q;
  logic                      start_q;
  logic [NUM_REQ-1:0]        done_q;
  logic [WdW-1:0]            wd_q;
  logic                      err_q;
  logic [7:0]                fail_cnt_q;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_found;

  dma_wr_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_arb (
    .req     (req_valid_i),
    .ptr     (ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .found   (arb_found)
  );

  // Job sequencing FSM; also owns grant/addr/len capture, watchdog and sticky error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      start_q <= 1'b0;
      done_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      // A timeout later in this block overrides the clear
      if (err_clr_i) err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req_valid_i) state_q <= StArb;
        end
        StArb: begin
          // Requests may be withdrawn before ack; nothing left means back to idle
          if (arb_found) begin
            grant_q <= arb_idx;
            addr_q  <= addr_arr[arb_idx];
            len_q   <= len_arr[arb_idx];
            if (len_arr[arb_idx] == '0) begin
              state_q <= StFin;
            end else begin
              state_q <= StStart;
              start_q <= 1'b1;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StStart: begin
          // Start cycle counts as the first watchdog cycle
          wd_q    <= WdW'(1);
          state_q <= StRun;
        end
        StRun: begin
          if (dma_done_i) begin
            state_q <= StFin;
          end else if (wd_q == WdW'(TIMEOUT - 1)) begin
            // Abort; the DMA itself is left for rstn to recover
            err_q   <= 1'b1;
            state_q <= StFin;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StFin: begin
          done_q[grant_q] <= 1'b1;
          ptr_q           <= IdxW'(rr_next(32'(grant_q), NUM_REQ));
          state_q         <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Saturating burst-failure counter; a failure in the same cycle as a clear is kept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fail_cnt_q <= '0;
    end else if (dma_fail_i) begin
      if (fail_cnt_q != FailCntMax) fail_cnt_q <= fail_cnt_q + 1'b1;
    end else if (err_clr_i) begin
      fail_cnt_q <= '0;
    end
  end

  // Ack in ARB; buffer strobe and data steered only to the granted requester while running
  always_comb begin
    req_ack_o    = '0;
    buf_rd_o     = '0;
    dma_indata_o = '0;
    if (state_q == StArb && arb_found) req_ack_o = arb_oh;
    if (state_q == StRun) begin
      buf_rd_o[grant_q] = dma_req_i;
      dma_indata_o      = data_arr[grant_q];
    end
  end

  assign req_done_o      = done_q;
  assign dma_start_o     = start_q;
  assign dma_num_trans_o = len_q;
  assign dma_addr_o      = addr_q;
  assign busy_o          = (state_q != StIdle);
  assign grant_o         = grant_q;
  assign fail_cnt_o      = fail_cnt_q;
  assign err_o           = err_q;

endmodule
